// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and baud helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Line levels shared with the receive side.
  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;

  // Clock cycles per serial bit; truncating division.
  function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                               input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;

  // Clear has priority so bit timing restarts exactly at the start bit.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Tick only depends on registered state, so it is glitch-free for the FSM.
  always_comb begin
    tick = enable && (count_q == LAST);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining an upstream fifo into 8N1/8N2 frames on the TX pin.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 RST_N,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_next;
  logic [BW-1:0]        bit_cnt_q;
  logic                 tx_q;
  logic                 read_q;
  logic                 busy_q;
  logic                 baud_clear;
  logic                 baud_enable;
  logic                 baud_tick;

  // Counter is zeroed during LOAD so the first START cycle is count 0.
  always_comb begin
    baud_clear  = (state_q == LOAD);
    baud_enable = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    shift_next  = shift_q >> 1;
  end

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLOCK_50(CLOCK_50),
    .RST_N   (RST_N),
    .clear   (baud_clear),
    .enable  (baud_enable),
    .tick    (baud_tick)
  );

  // Frame sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= TX_IDLE_LEVEL;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      read_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= TX_IDLE_LEVEL;
          if (!fifo_empty) begin
            state_q <= READ;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          state_q <= LOAD;
        end
        LOAD: begin
          // fifo data_out is valid in this cycle only.
          shift_q   <= fifo_data;
          bit_cnt_q <= '0;
          tx_q      <= START_LEVEL;
          state_q   <= START;
        end
        START: begin
          if (baud_tick) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift_q <= shift_next;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              tx_q      <= TX_IDLE_LEVEL;
              state_q   <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_next[0];
            end
          end
        end
        STOP: begin
          // bit_cnt_q is reused to count stop-bit periods.
          if (baud_tick) begin
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q <= '0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= TX_IDLE_LEVEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    tx        = tx_q;
    fifo_read = read_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances (8N1 @10 clk/bit, 8N2 @10, defaults @434).
module tb_fifo_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [2:0] fifo_read_w;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] empty_w;
  logic [7:0] data_w [3];

  // Simple fifo models: registered data_out, garbage when no read happened.
  logic [7:0] mem [3][16];
  int         wr_ptr [3] = '{0, 0, 0};
  int         rd_ptr [3] = '{0, 0, 0};

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_uart_tx #(
    .CLOCK_HZ (1000),
    .BAUD     (100),
    .DATA_BITS(8),
    .STOP_BITS(1)
  ) u_dut0 (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .fifo_data (data_w[0]),
    .fifo_empty(empty_w[0]),
    .fifo_read (fifo_read_w[0]),
    .tx        (tx_w[0]),
    .busy      (busy_w[0])
  );

  fifo_uart_tx #(
    .CLOCK_HZ (1000),
    .BAUD     (100),
    .DATA_BITS(8),
    .STOP_BITS(2)
  ) u_dut1 (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .fifo_data (data_w[1]),
    .fifo_empty(empty_w[1]),
    .fifo_read (fifo_read_w[1]),
    .tx        (tx_w[1]),
    .busy      (busy_w[1])
  );

  fifo_uart_tx u_dut2 (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .fifo_data (data_w[2]),
    .fifo_empty(empty_w[2]),
    .fifo_read (fifo_read_w[2]),
    .tx        (tx_w[2]),
    .busy      (busy_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) empty_w[i] = (wr_ptr[i] == rd_ptr[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fifo_read_w[i] && !empty_w[i]) begin
        data_w[i] <= mem[i][rd_ptr[i] % 16];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end else begin
        data_w[i] <= 8'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A read strobe must never hit an empty fifo.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fifo_read_w[i] === 1'b1) chk($sformatf("read_on_empty[%0d]", i), 32'(empty_w[i]), 0);
    end
  end

  task automatic push(input int sel, input logic [7:0] b);
    mem[sel][wr_ptr[sel] % 16] = b;
    wr_ptr[sel] = wr_ptr[sel] + 1;
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk($sformatf("%s tx[%0d]", tag, sel), 32'(tx_w[sel]), 1);
    chk($sformatf("%s busy[%0d]", tag, sel), 32'(busy_w[sel]), 0);
    chk($sformatf("%s read[%0d]", tag, sel), 32'(fifo_read_w[sel]), 0);
  endtask

  // Called on a negedge where the DUT is IDLE with a non-empty fifo.
  // Checks every cycle of the frame and ends on the following IDLE cycle.
  task automatic run_frame(input int sel, input logic [7:0] data, input int nstop,
                           input int cpb);
    int         len;
    int         k;
    logic       etx;
    logic [7:0] dec;
    len = 3 + cpb * (9 + nstop);
    dec = 8'h00;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c < 3 || c == len) begin
        etx = 1'b1;
      end else begin
        k = (c - 3) / cpb;
        if (k == 0) etx = 1'b0;
        else if (k <= 8) etx = data[k-1];
        else etx = 1'b1;
        if (k >= 1 && k <= 8 && ((c - 3) % cpb) == cpb / 2) dec[k-1] = tx_w[sel];
      end
      chk($sformatf("tx[%0d] byte %0h c=%0d", sel, data, c), 32'(tx_w[sel]), 32'(etx));
      chk($sformatf("busy[%0d] byte %0h c=%0d", sel, data, c), 32'(busy_w[sel]),
          32'(c < len));
      chk($sformatf("read[%0d] byte %0h c=%0d", sel, data, c), 32'(fifo_read_w[sel]),
          32'(c == 1));
    end
    chk($sformatf("decoded[%0d]", sel), 32'(dec), 32'(data));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, "in_reset");
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_idle(i, "reset_idle");
    end

    // Single byte.
    push(0, 8'hA5);
    run_frame(0, 8'hA5, 1, 10);
    repeat (5) @(negedge clk);

    // Back-to-back: the second frame starts straight from the one-cycle IDLE.
    push(0, 8'h00);
    push(0, 8'hFF);
    run_frame(0, 8'h00, 1, 10);
    run_frame(0, 8'hFF, 1, 10);
    repeat (5) @(negedge clk);

    // Two stop bits: START at c=3, IDLE at c=113 -> 110-cycle frame.
    push(1, 8'h55);
    run_frame(1, 8'h55, 2, 10);
    repeat (5) @(negedge clk);

    // Reset during the 4th data bit (bit index 3) of 0x0F.
    push(0, 8'h0F);
    for (int c = 1; c <= 47; c++) @(negedge clk);
    chk("mid_frame busy", 32'(busy_w[0]), 1);
    chk("mid_frame tx bit3", 32'(tx_w[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle(0, "after_reset_edge");
    push(0, 8'h3C);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk_idle(0, "reset_held");
    end
    rst_n = 1'b1;
    run_frame(0, 8'h3C, 1, 10);
    repeat (5) @(negedge clk);

    // Default parameters: 50 MHz / 115200 -> 434 cycles per bit.
    push(2, 8'h41);
    run_frame(2, 8'h41, 1, 434);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
